// File: rtl/fsm_2_decode_if.sv
// Handshake bundle between the chunk decoder and its two FIFOs.
// The encoded input FIFO is show-ahead (head valid while empty is low).
// The raw output FIFO asserts full while it cannot take a write.
interface fsm_2_decode_if;
  logic enc_data_in_fifo_empty;
  logic enc_data_in_first;
  logic enc_data_in_fifo_pop;
  logic raw_data_out_fifo_full;
  logic raw_data_out_fifo_push;
  logic raw_data_out_index_push;
  logic raw_data_out_wstrb_push;

  // FIFO / environment side
  modport master (
    output enc_data_in_fifo_empty,
    output enc_data_in_first,
    output raw_data_out_fifo_full,
    input  enc_data_in_fifo_pop,
    input  raw_data_out_fifo_push,
    input  raw_data_out_index_push,
    input  raw_data_out_wstrb_push
  );

  // Decoder side
  modport slave (
    input  enc_data_in_fifo_empty,
    input  enc_data_in_first,
    input  raw_data_out_fifo_full,
    output enc_data_in_fifo_pop,
    output raw_data_out_fifo_push,
    output raw_data_out_index_push,
    output raw_data_out_wstrb_push
  );
endinterface

// File: rtl/fsm_2_decode.sv
// Control FSM that gathers NUM_CHUNKS encoded chunks into one raw word.
// Latency: 2 cycles per chunk (WAIT_CHUNK+LOAD) plus WAIT_SPACE and WRITE.
// Backpressure: stalls in WAIT_CHUNK while input empty, in WAIT_SPACE while output full.
module fsm_2_decode #(
  parameter int NUM_CHUNKS = 4,
  parameter int WORD_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fsm_2_decode_if.slave         bus,
  output logic                  dec_load,
  output logic [1:0]            dec_sel,
  output logic                  dec_clr,
  output logic                  decode_err,
  output logic [WORD_CNT_W-1:0] word_count,
  output logic                  busy
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_CHUNKS - 1);

  typedef enum logic [4:0] {
    INIT       = 5'b00001,
    WAIT_CHUNK = 5'b00010,
    LOAD       = 5'b00100,
    WAIT_SPACE = 5'b01000,
    WRITE      = 5'b10000
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [WORD_CNT_W-1:0] word_count_q, word_count_d;

  // State, chunk index and word counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= INIT;
      idx_q        <= 2'd0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
    end
  end

  // Next-state and output decode; all strobes are forced low while in reset
  always_comb begin
    state_d                     = state_q;
    idx_d                       = idx_q;
    word_count_d                = word_count_q;
    bus.enc_data_in_fifo_pop    = 1'b0;
    bus.raw_data_out_fifo_push  = 1'b0;
    bus.raw_data_out_index_push = 1'b0;
    bus.raw_data_out_wstrb_push = 1'b0;
    dec_load                    = 1'b0;
    dec_clr                     = 1'b0;
    decode_err                  = 1'b0;
    busy                        = (idx_q != 2'd0) ||
                                  (state_q == LOAD) ||
                                  (state_q == WAIT_SPACE) ||
                                  (state_q == WRITE);

    case (state_q)
      INIT: begin
        dec_clr = 1'b1;
        idx_d   = 2'd0;
        state_d = WAIT_CHUNK;
      end
      WAIT_CHUNK: begin
        if (!bus.enc_data_in_fifo_empty) begin
          if (bus.enc_data_in_first && (idx_q != 2'd0)) begin
            // New word started early: drop the partial one and retry the head as chunk 0
            decode_err = 1'b1;
            dec_clr    = 1'b1;
            idx_d      = 2'd0;
          end else if (!bus.enc_data_in_first && (idx_q == 2'd0)) begin
            // Continuation chunk with no word in progress: discard it
            decode_err               = 1'b1;
            bus.enc_data_in_fifo_pop = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        bus.enc_data_in_fifo_pop = 1'b1;
        dec_load                 = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = WAIT_SPACE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = WAIT_CHUNK;
        end
      end
      WAIT_SPACE: begin
        if (!bus.raw_data_out_fifo_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        bus.raw_data_out_fifo_push  = 1'b1;
        bus.raw_data_out_index_push = 1'b1;
        bus.raw_data_out_wstrb_push = 1'b1;
        word_count_d                = word_count_q + WORD_CNT_W'(1);
        idx_d                       = 2'd0;
        dec_clr                     = 1'b1;
        state_d                     = WAIT_CHUNK;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    if (!reset) begin
      bus.enc_data_in_fifo_pop    = 1'b0;
      bus.raw_data_out_fifo_push  = 1'b0;
      bus.raw_data_out_index_push = 1'b0;
      bus.raw_data_out_wstrb_push = 1'b0;
      dec_load                    = 1'b0;
      dec_clr                     = 1'b0;
      decode_err                  = 1'b0;
      busy                        = 1'b0;
    end
  end

  assign dec_sel    = idx_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fsm_2_decode.sv
// Directed bench for fsm_2_decode: default instance fed from a show-ahead FIFO
// model, plus a NUM_CHUNKS=2 / WORD_CNT_W=4 instance streaming continuously.
// Cycle 1 is the INIT cycle right after reset release.
module tb_fsm_2_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rst2_n;
  logic        dec_load, dec_clr, decode_err, busy;
  logic [1:0]  dec_sel;
  logic [15:0] word_count;
  logic        dec_load2, dec_clr2, decode_err2, busy2;
  logic [1:0]  dec_sel2;
  logic [3:0]  word_count2;
  logic [3:0]  ctr2;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic q[$];
  logic popped;
  logic [1:0] sel_tab [0:12];

  fsm_2_decode_if bus ();
  fsm_2_decode_if bus2 ();

  fsm_2_decode u_dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus),
    .dec_load   (dec_load),
    .dec_sel    (dec_sel),
    .dec_clr    (dec_clr),
    .decode_err (decode_err),
    .word_count (word_count),
    .busy       (busy)
  );

  fsm_2_decode #(.NUM_CHUNKS(2), .WORD_CNT_W(4)) u_dut2 (
    .clk        (clk),
    .reset      (rst2_n),
    .bus        (bus2),
    .dec_load   (dec_load2),
    .dec_sel    (dec_sel2),
    .dec_clr    (dec_clr2),
    .decode_err (decode_err2),
    .word_count (word_count2),
    .busy       (busy2)
  );

  // Second instance: endless well-formed 2-chunk words, output never full
  assign bus2.enc_data_in_fifo_empty = 1'b0;
  assign bus2.enc_data_in_first      = ~ctr2[0];
  assign bus2.raw_data_out_fifo_full = 1'b0;
  always @(posedge clk) begin
    if (!rst2_n) ctr2 <= 4'd0;
    else if (bus2.enc_data_in_fifo_pop) ctr2 <= ctr2 + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.enc_data_in_fifo_empty = (q.size() == 0);
    bus.enc_data_in_first      = (q.size() != 0) ? q[0] : 1'b0;
  endtask

  // One clock: FIFO model honours the pop seen before the edge, inputs update after it
  task automatic tick();
    @(negedge clk);
    popped = bus.enc_data_in_fifo_pop;
    @(posedge clk);
    #1;
    if (popped && q.size() != 0) void'(q.pop_front());
    drive();
    #1;
    cyc++;
  endtask

  initial begin
    int  npush;
    int  last;
    bit  done;
    sel_tab = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus.raw_data_out_fifo_full = 1'b0;
    drive();
    repeat (3) tick();

    // Reset state: everything quiet even though the FSM sits in INIT
    chk("rst_pop",   bus.enc_data_in_fifo_pop, 0);
    chk("rst_push",  bus.raw_data_out_fifo_push, 0);
    chk("rst_load",  dec_load, 0);
    chk("rst_clr",   dec_clr, 0);
    chk("rst_err",   decode_err, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_sel",   dec_sel, 0);
    chk("rst_wc",    word_count, 0);

    // One clean word, output has space
    q = '{1'b1, 1'b0, 1'b0, 1'b0};
    drive();
    rst_n = 1'b1;
    #1;
    cyc = 1;
    chk("init_clr",  dec_clr, 1);
    chk("init_busy", busy, 0);
    for (int c = 2; c <= 12; c++) begin
      tick();
      chk($sformatf("w1_pop_c%0d", c),  bus.enc_data_in_fifo_pop, (c == 3 || c == 5 || c == 7 || c == 9));
      chk($sformatf("w1_load_c%0d", c), dec_load, (c == 3 || c == 5 || c == 7 || c == 9));
      chk($sformatf("w1_push_c%0d", c), bus.raw_data_out_fifo_push, (c == 11));
      chk($sformatf("w1_sel_c%0d", c),  dec_sel, sel_tab[c]);
      if (c == 11) begin
        chk("w1_idx_push",   bus.raw_data_out_index_push, 1);
        chk("w1_wstrb_push", bus.raw_data_out_wstrb_push, 1);
        chk("w1_write_clr",  dec_clr, 1);
      end
    end
    chk("w1_wc",   word_count, 1);
    chk("w1_busy", busy, 0);

    // Output full for 5 cycles after the last LOAD
    q = '{1'b1, 1'b0, 1'b0, 1'b0};
    bus.raw_data_out_fifo_full = 1'b1;
    drive();
    #1;
    repeat (7) tick();
    chk("w2_load3", dec_load, 1);
    chk("w2_sel3",  dec_sel, 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("w2_full_push_c%0d", cyc), bus.raw_data_out_fifo_push, 0);
      chk($sformatf("w2_full_busy_c%0d", cyc), busy, 1);
    end
    tick();
    bus.raw_data_out_fifo_full = 1'b0;
    #1;
    chk("w2_fall_push", bus.raw_data_out_fifo_push, 0);
    tick();
    chk("w2_push",     bus.raw_data_out_fifo_push, 1);
    chk("w2_push_pop", bus.enc_data_in_fifo_pop, 0);
    tick();
    chk("w2_wc", word_count, 2);

    // first=1 arriving at idx=2: error, clear, no pop, then reloaded as chunk 0
    q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    drive();
    #1;
    repeat (4) tick();
    chk("early_err", decode_err, 1);
    chk("early_clr", dec_clr, 1);
    chk("early_pop", bus.enc_data_in_fifo_pop, 0);
    chk("early_sel", dec_sel, 2);
    tick();
    chk("early_err_gone", decode_err, 0);
    chk("early_busy",     busy, 0);
    chk("early_sel0",     dec_sel, 0);
    tick();
    chk("early_reload",     dec_load, 1);
    chk("early_reload_sel", dec_sel, 0);
    chk("early_reload_pop", bus.enc_data_in_fifo_pop, 1);
    repeat (8) tick();
    chk("w3_push", bus.raw_data_out_fifo_push, 1);
    tick();
    chk("w3_wc", word_count, 3);

    // Orphan continuation chunk at idx=0: popped with an error, nothing loaded
    q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    drive();
    #1;
    chk("orphan_err",  decode_err, 1);
    chk("orphan_pop",  bus.enc_data_in_fifo_pop, 1);
    chk("orphan_load", dec_load, 0);
    chk("orphan_clr",  dec_clr, 0);
    tick();
    chk("orphan_err_gone", decode_err, 0);
    chk("orphan_busy",     busy, 0);
    chk("orphan_noload",   dec_load, 0);
    tick();
    chk("orphan_next_load", dec_load, 1);
    chk("orphan_next_sel",  dec_sel, 0);

    // Reset asserted during LOAD at idx=1 discards the partial word
    repeat (2) tick();
    chk("mid_load", dec_load, 1);
    chk("mid_sel",  dec_sel, 1);
    rst_n = 1'b0;
    q.delete();
    drive();
    #1;
    chk("mid_rst_load", dec_load, 0);
    chk("mid_rst_pop",  bus.enc_data_in_fifo_pop, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_init_clr", dec_clr, 1);
    chk("mid_init_wc",  word_count, 0);
    chk("mid_init_sel", dec_sel, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("mid_push_c%0d", cyc), bus.raw_data_out_fifo_push, 0);
      chk($sformatf("mid_err_c%0d", cyc),  decode_err, 0);
    end
    chk("mid_wc_end", word_count, 0);

    // Two-chunk, 4-bit-counter instance: push every 6 cycles, count wraps to 1 after 17
    rst2_n = 1'b1;
    npush  = 0;
    last   = 0;
    done   = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (bus2.raw_data_out_fifo_push === 1'b1) begin
        npush++;
        if (npush > 1) chk($sformatf("d2_period_%0d", npush), cyc - last, 6);
        last = cyc;
        if (npush == 17) begin
          tick();
          chk("d2_wc_wrap", word_count2, 1);
          done = 1;
        end
      end
    end
    if (!done) chk("d2_push_count", npush, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_2_decode.md
FSM_2_DECODE -- requirements
Module: fsm_2_decode

Interface
REQ-001 Parameter: NUM_CHUNKS, 4, encoded chunks per raw word; legal 2..4.
REQ-002 Parameter: WORD_CNT_W, 16, width of word_count.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 enc_data_in_fifo_empty  in  1  encoded FIFO empty; head entry valid when low (show-ahead).
REQ-006 enc_data_in_first  in  1  head entry is chunk 0 of a word.
REQ-007 enc_data_in_fifo_pop  out  1  removes head entry at the clock edge.
REQ-008 raw_data_out_fifo_full  in  1  raw output FIFO cannot accept a write.
REQ-009 raw_data_out_fifo_push, raw_data_out_index_push, raw_data_out_wstrb_push  out  1 each  write assembled word, index and strobe.
REQ-010 dec_load  out  1  datapath captures head chunk into lane dec_sel.
REQ-011 dec_sel  out  2  lane select; equals chunk index idx.
REQ-012 dec_clr  out  1  clears datapath assembly register.
REQ-013 decode_err  out  1  one-cycle framing-error pulse.
REQ-014 word_count  out  WORD_CNT_W  raw words written since reset.
REQ-015 busy  out  1  high when idx != 0 or state is LOAD, WAIT_SPACE or WRITE.

Function
REQ-016 States SHALL be INIT, WAIT_CHUNK, LOAD, WAIT_SPACE, WRITE, one-hot encoded; any illegal encoding -> INIT next cycle.
REQ-017 Internal idx register: width 2; range 0..NUM_CHUNKS-1.
REQ-018 Outputs not named as asserted in a state SHALL be 0; dec_sel SHALL always equal idx.
REQ-019 INIT: dec_clr=1, idx<=0; -> WAIT_CHUNK unconditionally.
REQ-020 WAIT_CHUNK, empty=1: hold; no outputs.
REQ-021 WAIT_CHUNK, empty=0, first=1, idx!=0: decode_err=1, dec_clr=1, idx<=0, no pop; remain in WAIT_CHUNK (head re-evaluated as chunk 0).
REQ-022 WAIT_CHUNK, empty=0, first=0, idx==0: decode_err=1, enc_data_in_fifo_pop=1 (orphan chunk discarded); remain in WAIT_CHUNK.
REQ-023 WAIT_CHUNK, otherwise with empty=0: -> LOAD.
REQ-024 LOAD: enc_data_in_fifo_pop=1, dec_load=1; if idx==NUM_CHUNKS-1 -> WAIT_SPACE with idx held, else idx<=idx+1 -> WAIT_CHUNK.
REQ-025 WAIT_SPACE: full=1 hold; full=0 -> WRITE.
REQ-026 WRITE: all three raw_data_out_*_push=1 for exactly one cycle, word_count<=word_count+1 (wraps modulo 2^WORD_CNT_W), idx<=0, dec_clr=1; -> WAIT_CHUNK.
REQ-027 Pop and push SHALL never be asserted in the same cycle; push SHALL never be asserted while full=1 was sampled in the preceding WAIT_SPACE cycle.
REQ-028 Best-case throughput: 2*NUM_CHUNKS+2 cycles per word (10 at default).
REQ-029 enc_data_in_first is ignored outside WAIT_CHUNK.

Reset
REQ-030 While reset=0 at a rising edge: state<=INIT, idx<=0, word_count<=0.
REQ-031 All outputs SHALL be 0 during reset except dec_sel=0 and word_count=0; first cycle after release is INIT (dec_clr=1).
REQ-032 Reset mid-word SHALL discard the partial word: no push, no decode_err, datapath cleared in INIT.

Verification
REQ-033 Reset release, FIFO fed 4 chunks (first on chunk 0), full=0 -> pops on cycles 3,5,7,9 after INIT, dec_sel 0,1,2,3, one push at cycle 11, word_count=1.
REQ-034 full=1 held 5 cycles after 4th LOAD -> WAIT_SPACE holds 5 cycles, no push; push exactly one cycle after full falls.
REQ-035 first=1 on chunk arriving at idx=2 -> decode_err pulse, dec_clr, no pop; that chunk then loaded with dec_sel=0.
REQ-036 first=0 on chunk at idx=0 -> decode_err and pop of that chunk, no dec_load, idx stays 0.
REQ-037 reset=0 asserted in LOAD at idx=1 -> next cycle INIT, word_count=0, no push ever for partial word.
REQ-038 WORD_CNT_W=4, 17 words decoded -> word_count wraps to 1; NUM_CHUNKS=2 run gives push every 6 cycles.
